// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_serializer
// Description : Captures the parallel outputs of a neuron layer in one cycle and
//               replays them as a serial word stream for the next layer.
//               Optional argmax tracking is enabled with macro MAXFIND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_output_serializer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [numNeurons*dataWidth-1:0]    layerOut,
    input  logic [numNeurons-1:0]              layerOutValid,
    output logic [dataWidth-1:0]               dataOut,
    output logic                               dataOutValid,
    output logic                               busy,
    output logic                               overrun,
`ifdef MAXFIND_EN
    output logic [$clog2(numNeurons)-1:0]      maxIdx,
    output logic [dataWidth-1:0]               maxValue,
    output logic                               maxValid,
`endif
    output logic                               validMismatch
);

    localparam int                c_CNT_W = $clog2(numNeurons);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(numNeurons - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_CNT_W-1:0]     cnt_q, cnt_d;
    logic [dataWidth-1:0]   data_q, data_d;
    logic [dataWidth-1:0]   mem_q [numNeurons];
    logic                   overrun_q, overrun_d;
    logic                   mismatch_q, mismatch_d;

    logic                   w_capture;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_drop;
    logic [c_CNT_W-1:0]     w_next_cnt;

    assign w_capture  = layerOutValid[0];
    assign w_last     = (state_q == ST_SHIFT) && (cnt_q == c_LAST);
    assign w_accept   = w_capture && ((state_q == ST_IDLE) || w_last);
    assign w_drop     = w_capture && (state_q == ST_SHIFT) && !w_last;
    assign w_next_cnt = cnt_q + c_CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        overrun_d  = overrun_q | w_drop;
        mismatch_d = mismatch_q |
                     ((layerOutValid != '0) && (layerOutValid != '1));
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    data_d  = layerOut[dataWidth-1:0];
                end
            end
            ST_SHIFT: begin
                // A capture on the last word chains the next burst with no gap.
                if (w_accept) begin
                    cnt_d  = '0;
                    data_d = layerOut[dataWidth-1:0];
                end else if (w_last) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d  = w_next_cnt;
                    data_d = mem_q[w_next_cnt];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int k = 0; k < numNeurons; k++) begin
                mem_q[k] <= layerOut[k*dataWidth +: dataWidth];
            end
        end
    end

    assign dataOut       = data_q;
    assign dataOutValid  = (state_q == ST_SHIFT);
    assign busy          = (state_q == ST_SHIFT);
    assign overrun       = overrun_q;
    assign validMismatch = mismatch_q;

`ifdef MAXFIND_EN
    logic signed [dataWidth-1:0] run_max_q;
    logic [c_CNT_W-1:0]          run_idx_q;
    logic signed [dataWidth-1:0] w_cand_val;
    logic [c_CNT_W-1:0]          w_cand_idx;
    logic [c_CNT_W-1:0]          max_idx_q;
    logic [dataWidth-1:0]        max_val_q;
    logic                        max_vld_q;

    // data_q holds word cnt_q during SHIFT; strict > keeps the lowest index on ties.
    always_comb begin
        w_cand_val = run_max_q;
        w_cand_idx = run_idx_q;
        if ((cnt_q == '0) || ($signed(data_q) > run_max_q)) begin
            w_cand_val = $signed(data_q);
            w_cand_idx = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q <= '0;
            run_idx_q <= '0;
            max_idx_q <= '0;
            max_val_q <= '0;
            max_vld_q <= 1'b0;
        end else begin
            max_vld_q <= w_last;
            if (state_q == ST_SHIFT) begin
                run_max_q <= w_cand_val;
                run_idx_q <= w_cand_idx;
            end
            if (w_last) begin
                max_idx_q <= w_cand_idx;
                max_val_q <= w_cand_val;
            end
        end
    end

    assign maxIdx   = max_idx_q;
    assign maxValue = max_val_q;
    assign maxValid = max_vld_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_output_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_output_serializer
// Description : Self-checking bench: a cycle-indexed stream model plus directed
//               literal expectations for the layer output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_output_serializer;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int IW    = $clog2(N);
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   layerOut;
    logic [N-1:0]     layerOutValid;
    logic [W-1:0]     dataOut;
    logic             dataOutValid;
    logic             busy;
    logic             overrun;
    logic             validMismatch;
`ifdef MAXFIND_EN
    logic [IW-1:0]    maxIdx;
    logic [W-1:0]     maxValue;
    logic             maxValid;
`endif

    layer_output_serializer #(
        .numNeurons (N),
        .dataWidth  (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .layerOut      (layerOut),
        .layerOutValid (layerOutValid),
        .dataOut       (dataOut),
        .dataOutValid  (dataOutValid),
        .busy          (busy),
        .overrun       (overrun),
`ifdef MAXFIND_EN
        .maxIdx        (maxIdx),
        .maxValue      (maxValue),
        .maxValid      (maxValid),
`endif
        .validMismatch (validMismatch)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected output stream, indexed by the cycle in which it must be visible.
    bit            exp_v    [DEPTH];
    logic [W-1:0]  exp_d    [DEPTH];
    bit            exp_mv   [DEPTH];
    logic [IW-1:0] exp_mi   [DEPTH];
    logic [W-1:0]  exp_mval [DEPTH];
    int            last_end = -1;
    bit            m_over   = 1'b0;
    bit            m_mis    = 1'b0;
    logic [IW-1:0] hold_idx = '0;
    logic [W-1:0]  hold_val = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a capture in cycle T is taken if the previous burst ends no later than T.
    always @(posedge clk) begin
        int            t;
        logic [W-1:0]  w;
        logic [W-1:0]  bv;
        logic [IW-1:0] bi;
        t = cyc;
        if (rst) begin
            for (int i = t + 1; i < DEPTH; i++) begin
                exp_v[i]  = 1'b0;
                exp_mv[i] = 1'b0;
            end
            last_end = t;
            m_over   = 1'b0;
            m_mis    = 1'b0;
            hold_idx = '0;
            hold_val = '0;
        end else begin
            if (layerOutValid != '0 && layerOutValid != '1)
                m_mis = 1'b1;
            if (layerOutValid[0]) begin
                if (t >= last_end) begin
                    bv = layerOut[W-1:0];
                    bi = '0;
                    for (int k = 0; k < N; k++) begin
                        w = layerOut[k*W +: W];
                        if (t + 1 + k < DEPTH) begin
                            exp_v[t+1+k] = 1'b1;
                            exp_d[t+1+k] = w;
                        end
                        if ($signed(w) > $signed(bv)) begin
                            bv = w;
                            bi = IW'(k);
                        end
                    end
                    if (t + N + 1 < DEPTH) begin
                        exp_mv[t+N+1]   = 1'b1;
                        exp_mi[t+N+1]   = bi;
                        exp_mval[t+N+1] = bv;
                    end
                    last_end = t + N;
                end else begin
                    m_over = 1'b1;
                end
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < DEPTH) begin
            chk("dataOutValid", dataOutValid, exp_v[cyc]);
            chk("busy", busy, exp_v[cyc]);
            if (exp_v[cyc])
                chk("dataOut", dataOut, exp_d[cyc]);
            chk("overrun", overrun, m_over);
            chk("validMismatch", validMismatch, m_mis);
`ifdef MAXFIND_EN
            if (exp_mv[cyc]) begin
                hold_idx = exp_mi[cyc];
                hold_val = exp_mval[cyc];
            end
            chk("maxValid", maxValid, exp_mv[cyc]);
            chk("maxIdx", maxIdx, hold_idx);
            chk("maxValue", maxValue, hold_val);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [N*W-1:0] A = 64'h0004_0003_0002_0001;
    localparam logic [N*W-1:0] B = 64'h0008_0007_0006_0005;

    initial begin
        rst           = 1'b1;
        layerOut      = '0;
        layerOutValid = '0;
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_valid", dataOutValid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_overrun", overrun, 1'b0);
        chk("reset_mismatch", validMismatch, 1'b0);
        chk("reset_dataOut", dataOut, 16'h0);
        tick();

        // Single burst
        layerOut = A; layerOutValid = '1;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("single_word", dataOut, 64'(c));
                chk("single_valid", dataOutValid, 1'b1);
            end else begin
                chk("single_end_valid", dataOutValid, 1'b0);
            end
            tick();
        end

        // Back-to-back: second capture on the last-word cycle
        layerOut = A; layerOutValid = '1;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 4) begin layerOut = B; layerOutValid = '1; end
            @(negedge clk);
            if (c <= 8) begin
                chk("b2b_word", dataOut, 64'(c));
                chk("b2b_valid", dataOutValid, 1'b1);
            end else begin
                chk("b2b_end_valid", dataOutValid, 1'b0);
            end
            tick(); layerOutValid = '0;
        end
        @(negedge clk);
        chk("b2b_overrun", overrun, 1'b0);
        tick();

        // Overrun: capture two cycles into a burst is dropped
        layerOut = A; layerOutValid = '1;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin layerOut = B; layerOutValid = '1; end
            @(negedge clk);
            if (c <= 4) chk("ovr_word", dataOut, 64'(c));
            else        chk("ovr_end_valid", dataOutValid, 1'b0);
            tick(); layerOutValid = '0;
        end
        @(negedge clk);
        chk("ovr_sticky", overrun, 1'b1);
        tick();

        // Reset mid-burst, then a fresh burst
        layerOut = A; layerOutValid = '1;
        tick(); layerOutValid = '0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_word", dataOut, 16'h2);
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", dataOutValid, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_overrun", overrun, 1'b0);
        tick();
        layerOut = B; layerOutValid = '1;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("post_rst_word", dataOut, 64'(c + 4));
            tick();
        end
        tick();

        // Capture on cnt == numNeurons-2 is still an overrun
        layerOut = A; layerOutValid = '1;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin layerOut = B; layerOutValid = '1; end
            @(negedge clk);
            if (c <= 4) chk("ovr3_word", dataOut, 64'(c));
            else        chk("ovr3_sticky", overrun, 1'b1);
            tick(); layerOutValid = '0;
        end

        // Partial valid vector: mismatch flagged, capture still on bit 0
        layerOut = 64'h0002_0007_0007_FFFD; layerOutValid = 4'b0101;
        tick(); layerOutValid = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("mis_flag", validMismatch, 1'b1);
                chk("mis_word0", dataOut, 16'hFFFD);
            end
`ifdef MAXFIND_EN
            if (c == 5) begin
                chk("argmax_valid", maxValid, 1'b1);
                chk("argmax_idx", maxIdx, 2'd1);
                chk("argmax_value", maxValue, 16'h0007);
            end
`endif
            tick();
        end

        // All-negative burst with a tie on the maximum
        layerOut = 64'hFFF9_FFFF_FFFB_FFFF; layerOutValid = '1;
        tick(); layerOutValid = '0;
        repeat (7) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
